game_state_ctrl: RTL and testbench

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

---
 rtl/game_state_ctrl_pkg.sv | 15 +
 rtl/game_state_ctrl_btn_debounce.sv | 58 +++++
 rtl/game_state_ctrl.sv | 137 +++++++++++++
 tb/tb_game_state_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_state_ctrl_pkg.sv
// Shared definitions for the game-state controller and the sprite drawers.
package game_state_ctrl_pkg;

  typedef enum logic [1:0] {
    GS_IDLE = 2'b00,
    GS_RUN  = 2'b01,
    GS_OVER = 2'b10
  } gamestate_e;

  localparam int unsigned DEF_DEBOUNCE_FRAMES = 3;
  localparam int unsigned DEF_LOCK_FRAMES     = 30;
  localparam int unsigned DEF_BLINK_FRAMES    = 8;
  localparam int unsigned DEF_SCORE_DIV       = 6;

endpackage

// File: rtl/game_state_ctrl_btn_debounce.sv
// Button synchronizer, frame-rate debouncer and press-event (rising edge) detector.
module btn_debounce
  import game_state_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_FRAMES + 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             press_q, press_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CNT_W'(1);
    if (frame_tick) begin
      if (sync2_q != level_q) begin
        if (cnt_inc == CNT_W'(DEBOUNCE_FRAMES)) begin
          level_d = sync2_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end else begin
        cnt_d = '0;
      end
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game FSM (idle/run/over), score divider, restart lockout and restart-sprite blink.
module game_state_ctrl
  import game_state_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
  parameter int unsigned LOCK_FRAMES     = DEF_LOCK_FRAMES,
  parameter int unsigned BLINK_FRAMES    = DEF_BLINK_FRAMES,
  parameter int unsigned SCORE_DIV       = DEF_SCORE_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_raw,
  input  logic        collision,
  output logic [1:0]  gamestate,
  output logic        restart_visible,
  output logic        restart_pulse,
  output logic        jump_pulse,
  output logic [15:0] score
);

  localparam int unsigned DIV_W   = $clog2(SCORE_DIV + 1);
  localparam int unsigned LOCK_W  = $clog2(LOCK_FRAMES + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES + 1);

  gamestate_e         state_q, state_d;
  logic [15:0]        score_q, score_d;
  logic [DIV_W-1:0]   div_q, div_d, div_inc;
  logic [LOCK_W-1:0]  lock_q, lock_d, lock_dec;
  logic [BLINK_W-1:0] blink_q, blink_d, blink_inc;
  logic               vis_q, vis_d;
  logic               restart_q, restart_d;
  logic               jump_q, jump_d;
  logic               press;

  btn_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_btn_debounce (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .btn_raw   (btn_raw),
    .press     (press)
  );

  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    div_d     = div_q;
    lock_d    = lock_q;
    blink_d   = blink_q;
    vis_d     = vis_q;
    restart_d = 1'b0;
    jump_d    = 1'b0;
    div_inc   = div_q + DIV_W'(1);
    lock_dec  = lock_q - LOCK_W'(1);
    blink_inc = blink_q + BLINK_W'(1);
    case (state_q)
      GS_IDLE: begin
        if (press) begin
          state_d   = GS_RUN;
          restart_d = 1'b1;
          score_d   = '0;
          div_d     = '0;
        end
      end
      GS_RUN: begin
        jump_d = press;
        if (frame_tick) begin
          if (collision) begin
            state_d = GS_OVER;
            lock_d  = LOCK_W'(LOCK_FRAMES);
            blink_d = '0;
            vis_d   = 1'b1;
          end else if (div_inc == DIV_W'(SCORE_DIV)) begin
            div_d   = '0;
            score_d = score_q + 16'd1;
          end else begin
            div_d = div_inc;
          end
        end
      end
      GS_OVER: begin
        // Presses during lockout are dropped; once unlocked the sprite stays lit.
        if (lock_q == '0) begin
          if (press) begin
            state_d   = GS_RUN;
            restart_d = 1'b1;
            score_d   = '0;
            div_d     = '0;
            vis_d     = 1'b0;
          end
        end else if (frame_tick) begin
          lock_d = lock_dec;
          if (lock_dec == '0) begin
            vis_d = 1'b1;
          end else if (blink_inc == BLINK_W'(BLINK_FRAMES)) begin
            blink_d = '0;
            vis_d   = ~vis_q;
          end else begin
            blink_d = blink_inc;
          end
        end
      end
      default: state_d = GS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= GS_IDLE;
      score_q   <= '0;
      div_q     <= '0;
      lock_q    <= '0;
      blink_q   <= '0;
      vis_q     <= 1'b0;
      restart_q <= 1'b0;
      jump_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      div_q     <= div_d;
      lock_q    <= lock_d;
      blink_q   <= blink_d;
      vis_q     <= vis_d;
      restart_q <= restart_d;
      jump_q    <= jump_d;
    end
  end

  assign gamestate       = state_q;
  assign score           = score_q;
  assign restart_visible = vis_q;
  assign restart_pulse   = restart_q;
  assign jump_pulse      = jump_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: directed table, corner sequences, random vs reference model.
module tb_game_state_ctrl;

  localparam int DEB   = 3;
  localparam int LOCK  = 30;
  localparam int BLINK = 8;
  localparam int DIV   = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        btn_raw = 1'b0;
  logic        collision = 1'b0;
  logic [1:0]  gamestate;
  logic        restart_visible;
  logic        restart_pulse;
  logic        jump_pulse;
  logic [15:0] score;

  game_state_ctrl #(
    .DEBOUNCE_FRAMES(DEB),
    .LOCK_FRAMES    (LOCK),
    .BLINK_FRAMES   (BLINK),
    .SCORE_DIV      (DIV)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick     (frame_tick),
    .btn_raw        (btn_raw),
    .collision      (collision),
    .gamestate      (gamestate),
    .restart_visible(restart_visible),
    .restart_pulse  (restart_pulse),
    .jump_pulse     (jump_pulse),
    .score          (score)
  );

  always #5 clk = ~clk;

  int n_checks  = 0;
  int n_pass    = 0;
  int n_restart = 0;
  int n_jump    = 0;

  // Reference model: game mode 0 idle, 1 run, 2 over; score and blink derived from frame counts.
  bit m_s1, m_s2, m_db, m_press, m_jump, m_restart;
  int m_mis, m_mode, m_run_frames, m_over_frames, m_score;

  function automatic void model_reset();
    m_s1 = 0; m_s2 = 0; m_db = 0; m_press = 0; m_jump = 0; m_restart = 0;
    m_mis = 0; m_mode = 0; m_run_frames = 0; m_over_frames = 0; m_score = 0;
  endfunction

  function automatic void model_step(bit t, bit b, bit c);
    bit press_old = m_press;
    bit db_old    = m_db;
    if (t) begin
      if (m_s2 != m_db) begin
        m_mis++;
        if (m_mis == DEB) begin
          m_db  = m_s2;
          m_mis = 0;
        end
      end else begin
        m_mis = 0;
      end
    end
    m_s2      = m_s1;
    m_s1      = b;
    m_press   = m_db && !db_old;
    m_jump    = (m_mode == 1) && press_old;
    m_restart = 0;
    case (m_mode)
      0: if (press_old) begin
        m_mode = 1; m_run_frames = 0; m_score = 0; m_restart = 1;
      end
      1: if (t && c) begin
        m_mode = 2; m_over_frames = 0;
      end else if (t) begin
        m_run_frames++;
        m_score = (m_run_frames / DIV) % 65536;
      end
      default: if (press_old && m_over_frames >= LOCK) begin
        m_mode = 1; m_run_frames = 0; m_score = 0; m_restart = 1;
      end else if (t) begin
        m_over_frames++;
      end
    endcase
  endfunction

  function automatic int model_vis();
    if (m_mode != 2) return 0;
    if (m_over_frames >= LOCK) return 1;
    return ((m_over_frames / BLINK) % 2 == 0) ? 1 : 0;
  endfunction

  function automatic int model_out();
    return (m_mode << 19) | (model_vis() << 18) | (int'(m_restart) << 17) |
           (int'(m_jump) << 16) | m_score;
  endfunction

  function automatic int dut_out();
    return int'({gamestate, restart_visible, restart_pulse, jump_pulse, score});
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc(input bit t, input bit b, input bit c);
    frame_tick = t;
    btn_raw    = b;
    collision  = c;
    @(posedge clk);
    model_step(t, b, c);
    #1;
    if (restart_pulse) n_restart++;
    if (jump_pulse) n_jump++;
    check("model", dut_out(), model_out());
  endtask

  task automatic frame(input bit b, input bit c);
    cyc(1'b1, b, c);
    cyc(1'b0, b, c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    frame_tick = 1'b0;
    btn_raw    = 1'b0;
    collision  = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    check("reset_state", dut_out(), 0);
    rst = 1'b0;
  endtask

  typedef struct {
    bit       btn;
    bit       col;
    bit [1:0] st;
  } vec_t;

  vec_t vecs[8];
  int   base_r, base_j;
  bit   rb;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 2'b00};  // single-frame glitch
    vecs[1] = '{1'b0, 1'b0, 2'b00};
    vecs[2] = '{1'b0, 1'b0, 2'b00};
    vecs[3] = '{1'b0, 1'b0, 2'b00};
    vecs[4] = '{1'b1, 1'b0, 2'b00};  // held press
    vecs[5] = '{1'b1, 1'b0, 2'b00};
    vecs[6] = '{1'b1, 1'b0, 2'b00};
    vecs[7] = '{1'b1, 1'b0, 2'b01};

    model_reset();
    do_reset();

    for (int i = 0; i < 8; i++) begin
      frame(vecs[i].btn, vecs[i].col);
      check("table_state", int'(gamestate), int'(vecs[i].st));
    end
    check("start_restart_count", n_restart, 1);
    check("start_score", int'(score), 0);

    // 60 running frames, then a collision
    for (int i = 0; i < 60; i++) frame(1'b0, 1'b0);
    check("score_after_60", int'(score), 10);
    check("run_state", int'(gamestate), 1);
    frame(1'b0, 1'b1);
    check("over_state", int'(gamestate), 2);
    check("score_frozen", int'(score), 10);
    check("vis_on_entry", int'(restart_visible), 1);

    // lockout: press near frame 10 ignored, blink, then accepted restart
    base_r = n_restart;
    base_j = n_jump;
    for (int k = 1; k <= 35; k++) begin
      frame(((k >= 7 && k <= 12) || k >= 32), 1'b0);
      if (k == 7 || k == 16 || k == 30) check("blink_on", int'(restart_visible), 1);
      if (k == 8 || k == 24 || k == 29) check("blink_off", int'(restart_visible), 0);
      if (k == 14) begin
        check("locked_press_ignored", n_restart, base_r);
        check("locked_state", int'(gamestate), 2);
      end
    end
    check("restart_state", int'(gamestate), 1);
    check("restart_score", int'(score), 0);
    check("restart_pulse", int'(restart_pulse), 1);
    check("restart_count", n_restart, base_r + 1);
    check("no_jump_in_over", n_jump, base_j);

    // collision and press land in the same cycle
    for (int i = 0; i < 6; i++) frame(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    check("simul_jump", int'(jump_pulse), 1);
    check("simul_state", int'(gamestate), 2);

    // asynchronous reset mid-run at score 0x0123
    do_reset();
    for (int i = 0; i < 4; i++) frame(1'b1, 1'b0);
    check("rerun_state", int'(gamestate), 1);
    for (int i = 0; i < 291 * DIV; i++) cyc(1'b1, 1'b0, 1'b0);
    check("score_0123", int'(score), 'h123);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", dut_out(), 0);
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    base_r = n_restart;
    base_j = n_jump;
    for (int i = 0; i < 10; i++) frame(1'b0, 1'b0);
    check("post_reset_restart", n_restart, base_r);
    check("post_reset_jump", n_jump, base_j);
    check("post_reset_state", int'(gamestate), 0);

    // randomized traffic against the model
    do_reset();
    rb = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) rb = ~rb;
      cyc(($urandom_range(0, 2) == 0), rb, ($urandom_range(0, 24) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
